// File: rtl/cpu_axi_pkg.sv
// Shared types and constants for the CPU-side AXI-Lite master.
package cpu_axi_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 32;
    localparam int DEFAULT_DATA_WIDTH = 32;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WR_AW_W,
        WR_B,
        RD_AR,
        RD_R,
        RESP
    } state_t;

    // SLVERR and DECERR both have bit 1 set; compare whole codes so every bit is consumed.
    function automatic logic resp_is_error(input logic [1:0] resp);
        return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
    endfunction

endpackage

// File: rtl/cpu_axi_lite_master.sv
// Single-outstanding CPU load/store to AXI-Lite master with a one-cycle response pulse.
// Optional alignment rejection of unaligned requests: define CPU_AXI_ALIGN_CHECK_EN.
module cpu_axi_lite_master
    import cpu_axi_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rstn,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,

    output logic [ADDR_WIDTH-1:0] M_AXI_AWADDR,
    output logic                  M_AXI_AWVALID,
    input  logic                  M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0] M_AXI_WDATA,
    output logic                  M_AXI_WVALID,
    input  logic                  M_AXI_WREADY,
    input  logic [1:0]            M_AXI_BRESP,
    input  logic                  M_AXI_BVALID,
    output logic                  M_AXI_BREADY,
    output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic                  M_AXI_ARVALID,
    input  logic                  M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0] M_AXI_RDATA,
    input  logic [1:0]            M_AXI_RRESP,
    input  logic                  M_AXI_RVALID,
    output logic                  M_AXI_RREADY
);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  arvalid_q, arvalid_d;
    logic                  err_q, err_d;
    logic                  misaligned;

`ifdef CPU_AXI_ALIGN_CHECK_EN
    assign misaligned = (req_addr[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            awaddr_q  <= '0;
            araddr_q  <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            awaddr_q  <= awaddr_d;
            araddr_q  <= araddr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            arvalid_q <= arvalid_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        awaddr_d  = awaddr_q;
        araddr_d  = araddr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        arvalid_d = arvalid_q;
        err_d     = err_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (misaligned) begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else if (req_we) begin
                        awaddr_d  = req_addr;
                        wdata_d   = req_wdata;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR_AW_W;
                    end else begin
                        araddr_d  = req_addr;
                        arvalid_d = 1'b1;
                        state_d   = RD_AR;
                    end
                end
            end
            // AW and W complete independently; leave once neither is still pending.
            WR_AW_W: begin
                if (M_AXI_AWREADY) awvalid_d = 1'b0;
                if (M_AXI_WREADY)  wvalid_d  = 1'b0;
                if ((!awvalid_q || M_AXI_AWREADY) && (!wvalid_q || M_AXI_WREADY))
                    state_d = WR_B;
            end
            WR_B: begin
                if (M_AXI_BVALID) begin
                    err_d   = resp_is_error(M_AXI_BRESP);
                    rdata_d = '0;
                    state_d = RESP;
                end
            end
            RD_AR: begin
                if (M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    state_d   = RD_R;
                end
            end
            RD_R: begin
                if (M_AXI_RVALID) begin
                    rdata_d = M_AXI_RDATA;
                    err_d   = resp_is_error(M_AXI_RRESP);
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign req_ready     = (state_q == IDLE);
    assign rsp_valid     = (state_q == RESP);
    assign rsp_rdata     = rdata_q;
    assign rsp_err       = err_q;
    assign M_AXI_AWADDR  = awaddr_q;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = (state_q == WR_B);
    assign M_AXI_ARADDR  = araddr_q;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = (state_q == RD_R);

endmodule

// File: tb/tb_cpu_axi_lite_master.sv
// Scoreboard bench for cpu_axi_lite_master against a small AXI-Lite memory slave with configurable delays.
// Alignment-reject expectations follow CPU_AXI_ALIGN_CHECK_EN.
module tb_cpu_axi_lite_master;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
    logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
    logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
    logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
    logic        M_AXI_RVALID, M_AXI_RREADY;

    always #5 clk = ~clk;

    cpu_axi_lite_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID),
        .M_AXI_RREADY(M_AXI_RREADY)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc_cyc;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    exp_t exp_cur;
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   rsp_count = 0;
    int   viol = 0;
    int   awv_cycles = 0, wv_cycles = 0, arv_cycles = 0;
    int   last_acc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Slave model: ready after a per-channel delay, response after a per-channel delay.
    int          aw_delay = 0, w_delay = 0, ar_delay = 0, b_delay = 0, r_delay = 0;
    logic [1:0]  b_resp = 2'b00, r_resp = 2'b00;
    logic [31:0] mem [0:15];
    int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    logic        aw_got, w_got, b_busy, r_busy, bvalid_r, rvalid_r;
    logic [31:0] aw_lat, wd_lat, rdata_r;
    logic        aw_hs, w_hs, ar_hs;
    logic [31:0] wr_addr, wr_data;

    assign M_AXI_AWREADY = M_AXI_AWVALID && (aw_cnt >= aw_delay);
    assign M_AXI_WREADY  = M_AXI_WVALID && (w_cnt >= w_delay);
    assign M_AXI_ARREADY = M_AXI_ARVALID && (ar_cnt >= ar_delay);
    assign aw_hs   = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_hs    = M_AXI_WVALID && M_AXI_WREADY;
    assign ar_hs   = M_AXI_ARVALID && M_AXI_ARREADY;
    assign wr_addr = aw_hs ? M_AXI_AWADDR : aw_lat;
    assign wr_data = w_hs ? M_AXI_WDATA : wd_lat;
    assign M_AXI_BVALID = bvalid_r;
    assign M_AXI_BRESP  = b_resp;
    assign M_AXI_RVALID = rvalid_r;
    assign M_AXI_RRESP  = r_resp;
    assign M_AXI_RDATA  = rdata_r;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; b_busy <= 1'b0; r_busy <= 1'b0;
            bvalid_r <= 1'b0; rvalid_r <= 1'b0; rdata_r <= '0;
            aw_lat <= '0; wd_lat <= '0;
        end else begin
            aw_cnt <= (M_AXI_AWVALID && !M_AXI_AWREADY) ? aw_cnt + 1 : 0;
            w_cnt  <= (M_AXI_WVALID && !M_AXI_WREADY) ? w_cnt + 1 : 0;
            ar_cnt <= (M_AXI_ARVALID && !M_AXI_ARREADY) ? ar_cnt + 1 : 0;
            if (aw_hs) begin aw_got <= 1'b1; aw_lat <= M_AXI_AWADDR; end
            if (w_hs)  begin w_got <= 1'b1;  wd_lat <= M_AXI_WDATA;  end
            if (!b_busy && !bvalid_r && (aw_got || aw_hs) && (w_got || w_hs)) begin
                mem[wr_addr[5:2]] <= wr_data;
                aw_got <= 1'b0;
                w_got  <= 1'b0;
                if (b_delay == 0) bvalid_r <= 1'b1;
                else begin b_busy <= 1'b1; b_cnt <= b_delay - 1; end
            end
            if (b_busy) begin
                if (b_cnt == 0) begin bvalid_r <= 1'b1; b_busy <= 1'b0; end
                else b_cnt <= b_cnt - 1;
            end
            if (bvalid_r && M_AXI_BREADY) bvalid_r <= 1'b0;
            if (ar_hs) begin
                rdata_r <= mem[M_AXI_ARADDR[5:2]];
                if (r_delay == 0) rvalid_r <= 1'b1;
                else begin r_busy <= 1'b1; r_cnt <= r_delay - 1; end
            end
            if (r_busy) begin
                if (r_cnt == 0) begin rvalid_r <= 1'b1; r_busy <= 1'b0; end
                else r_cnt <= r_cnt - 1;
            end
            if (rvalid_r && M_AXI_RREADY) rvalid_r <= 1'b0;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Monitor: protocol tracking plus scoreboard pop on every response pulse.
    logic        p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
    logic [31:0] p_awaddr, p_wdata, p_araddr;

    always @(negedge clk) begin
        if (!rstn) begin
            p_awv = 1'b0; p_wv = 1'b0; p_arv = 1'b0;
            p_awr = 1'b0; p_wr = 1'b0; p_arr = 1'b0;
        end else begin
            if (M_AXI_AWVALID) awv_cycles++;
            if (M_AXI_WVALID)  wv_cycles++;
            if (M_AXI_ARVALID) arv_cycles++;
            if (p_awv && !p_awr && (!M_AXI_AWVALID || M_AXI_AWADDR !== p_awaddr)) viol++;
            if (p_wv && !p_wr && (!M_AXI_WVALID || M_AXI_WDATA !== p_wdata)) viol++;
            if (p_arv && !p_arr && (!M_AXI_ARVALID || M_AXI_ARADDR !== p_araddr)) viol++;
            if (M_AXI_ARVALID && (M_AXI_AWVALID || M_AXI_WVALID)) viol++;
            if (req_ready && (M_AXI_AWVALID || M_AXI_WVALID || M_AXI_ARVALID ||
                              M_AXI_BREADY || M_AXI_RREADY || rsp_valid)) viol++;
            p_awv = M_AXI_AWVALID; p_awr = M_AXI_AWREADY; p_awaddr = M_AXI_AWADDR;
            p_wv  = M_AXI_WVALID;  p_wr  = M_AXI_WREADY;  p_wdata  = M_AXI_WDATA;
            p_arv = M_AXI_ARVALID; p_arr = M_AXI_ARREADY; p_araddr = M_AXI_ARADDR;

            if (rsp_valid) begin
                rsp_count++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_rsp: got rsp_valid=1 rdata=0x%0h err=%0b, expected none", rsp_rdata, rsp_err);
                end else begin
                    exp_cur = exp_q.pop_front();
                    checkOutput("rsp_rdata", rsp_rdata, exp_cur.rdata);
                    checkOutput("rsp_err", rsp_err, exp_cur.err);
                    if (exp_cur.lat > 0)
                        checkOutput("rsp_latency", cyc - exp_cur.acc_cyc, exp_cur.lat);
                end
            end
        end
    end

    task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] data,
                                 input logic push, input logic [31:0] exp_rdata, input logic exp_err,
                                 input int lat, input logic keep);
        int waited = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = data;
        while (!req_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("req_accept", req_ready, 1);
        if (!req_ready) begin
            req_valid = 1'b0;
            return;
        end
        last_acc = cyc;
        if (push) exp_q.push_back('{rdata: exp_rdata, err: exp_err, acc_cyc: cyc, lat: lat});
        @(posedge clk);
        #1;
        if (!keep) req_valid = 1'b0;
    endtask

    task automatic waitDone();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        checkOutput("rsp_drained", exp_q.size(), 0);
        @(negedge clk);
    endtask

    int base;
    int first_acc;

    initial begin
        rstn = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset_axi_vr", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY}, 0);
        checkOutput("reset_rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
        checkOutput("reset_req_ready", req_ready, 1);
        checkOutput("reset_addr", {M_AXI_AWADDR, M_AXI_ARADDR}, 0);
        rstn = 1'b1;

        // Basic store then load, always-ready slave.
        applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0, 3, 1'b0);
        checkOutput("t1_aw_w_valid", {M_AXI_AWVALID, M_AXI_WVALID}, 2'b11);
        checkOutput("t1_awaddr", M_AXI_AWADDR, 32'h10);
        checkOutput("t1_wdata", M_AXI_WDATA, 32'hDEADBEEF);
        @(posedge clk); #1;
        checkOutput("t1_bready", M_AXI_BREADY, 1);
        waitDone();
        applyStimulus(1'b0, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0, 3, 1'b0);
        checkOutput("t1_arvalid", M_AXI_ARVALID, 1);
        checkOutput("t1_araddr", M_AXI_ARADDR, 32'h10);
        waitDone();

        // AWREADY delayed 3 cycles, WREADY immediate.
        aw_delay = 3; awv_cycles = 0; wv_cycles = 0; base = rsp_count;
        applyStimulus(1'b1, 32'h14, 32'hA5A50F0F, 1'b1, 32'h0, 1'b0, 6, 1'b0);
        waitDone();
        checkOutput("t2_awvalid_cycles", awv_cycles, 4);
        checkOutput("t2_wvalid_cycles", wv_cycles, 1);
        checkOutput("t2_rsp_pulses", rsp_count - base, 1);
        aw_delay = 0;

        // RVALID delayed 5 cycles with SLVERR.
        r_delay = 5; r_resp = 2'b10; base = rsp_count;
        applyStimulus(1'b0, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF, 1'b1, 8, 1'b0);
        waitDone();
        checkOutput("t3_rsp_pulses", rsp_count - base, 1);
        r_delay = 0; r_resp = 2'b00;

        // Back-to-back with req_valid held high.
        applyStimulus(1'b1, 32'h20, 32'h12345678, 1'b1, 32'h0, 1'b0, 3, 1'b1);
        first_acc = last_acc;
        applyStimulus(1'b0, 32'h20, 32'h0, 1'b1, 32'h12345678, 1'b0, 3, 1'b0);
        checkOutput("t4_accept_gap", last_acc - first_acc, 4);
        waitDone();

        // Reset while waiting for B.
        b_delay = 5; base = rsp_count;
        applyStimulus(1'b1, 32'h30, 32'hCAFEF00D, 1'b0, 32'h0, 1'b0, 0, 1'b0);
        for (int i = 0; i < 20 && !M_AXI_BREADY; i++) @(negedge clk);
        checkOutput("t5_in_wr_b", M_AXI_BREADY, 1);
        #2 rstn = 1'b0;
        #1;
        checkOutput("t5_reset_vr", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY, rsp_valid}, 0);
        b_delay = 0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("t5_no_rsp", rsp_count - base, 0);
        applyStimulus(1'b0, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0, 3, 1'b0);
        waitDone();

        // Unaligned load.
        arv_cycles = 0;
`ifdef CPU_AXI_ALIGN_CHECK_EN
        applyStimulus(1'b0, 32'h13, 32'h0, 1'b1, 32'h0, 1'b1, 1, 1'b0);
        waitDone();
        checkOutput("t6_no_arvalid", arv_cycles, 0);
`else
        applyStimulus(1'b0, 32'h13, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0, 3, 1'b0);
        checkOutput("t6_araddr_passthru", M_AXI_ARADDR, 32'h13);
        waitDone();
        checkOutput("t6_arvalid_cycles", arv_cycles, 1);
`endif

        checkOutput("protocol_violations", viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog");
    end

endmodule

// File: doc/cpu_axi_lite_master.md
Name: cpu_axi_lite_master

Overview:
- Upstream neighbour of the AXI-Lite memory slave.
- Converts single-word CPU load/store requests into AXI-Lite read or write transactions on the SoC bus, which feeds the memory slave and the AXI-to-SPI bridge.
- Returns read data and error status to the CPU as a one-cycle response pulse.
- One transaction outstanding at a time.

Parameters:
- ADDR_WIDTH, 32, width of CPU address and AXI AWADDR/ARADDR.
- DATA_WIDTH, 32, width of CPU data and AXI WDATA/RDATA.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- req_valid  in  1  CPU request present
- req_ready  out  1  block accepts request this cycle
- req_we  in  1  1 = store, 0 = load
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  DATA_WIDTH  store data
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  DATA_WIDTH  load data; 0 for stores
- rsp_err  out  1  bus error (RESP[1] set) or local reject
- M_AXI_AWADDR/AWVALID/AWREADY  out/out/in  ADDR_WIDTH/1/1  write address channel
- M_AXI_WDATA/WVALID/WREADY  out/out/in  DATA_WIDTH/1/1  write data channel
- M_AXI_BRESP/BVALID/BREADY  in/in/out  2/1/1  write response channel
- M_AXI_ARADDR/ARVALID/ARREADY  out/out/in  ADDR_WIDTH/1/1  read address channel
- M_AXI_RDATA/RRESP/RVALID/RREADY  in/in/in/out  DATA_WIDTH/2/1/1  read data channel

Behaviour:
- Clock and reset: clk; reset rstn, asynchronous, active-low.
- Reset values: state IDLE; all VALID/READY outputs 0; address, data, rsp_rdata and rsp_err registers 0.
- Reset mid-transaction: everything returns to IDLE immediately and the transaction is dropped; no rsp_valid is produced.
- FSM states: IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RESP.
- IDLE: req_ready=1.
  - On req_valid && !req_we: latch req_addr into ARADDR, set ARVALID, go to RD_AR.
  - On req_valid && req_we: latch req_addr into AWADDR and req_wdata into WDATA, set AWVALID and WVALID, go to WR_AW_W.
- WR_AW_W:
  - AWVALID and WVALID each drop independently on their own handshake.
  - Either may complete first, or both in the same cycle.
  - Go to WR_B once both handshakes are done, including the case where both complete in the same cycle.
  - AWADDR and WDATA stay stable while their VALID is high.
- WR_B: BREADY=1 (derived from state). On BVALID, capture rsp_err=BRESP[1], set rsp_rdata=0, go to RESP.
- RD_AR: ARVALID held until ARREADY, then ARVALID=0 and go to RD_R.
- RD_R: RREADY=1. On RVALID, capture rsp_rdata=RDATA and rsp_err=RRESP[1], go to RESP.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. The CPU always accepts the response.
- req_ready=0 in every state except IDLE. A new request is accepted, at the earliest, the cycle after the rsp_valid pulse.
- Latency against an always-ready slave with one-cycle response: accept at cycle 0, AXI handshake at cycle 1, B/R handshake at cycle 2, rsp_valid at cycle 3. Four cycles per transaction.
- VALID signals are never dropped before their handshake, per the AXI rule.
- READY signals do not depend on the slave's VALID.

Optional Feature:
- Macro: CPU_AXI_ALIGN_CHECK_EN.
- Defined: a request with req_addr[1:0] != 0 is accepted but issues no AXI transaction. The FSM goes IDLE → RESP with rsp_err=1 and rsp_rdata=0, so rsp_valid comes one cycle after acceptance.
- Undefined: the address is passed through unchanged. Low bits are ignored by the slaves.

Decomposition:
- Package cpu_axi_pkg holds:
  - state enum typedef;
  - AXI response constants RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11;
  - the shared ADDR_WIDTH/DATA_WIDTH defaults.
- No sub-module: a single FSM of this size does not justify one.

Test Plan:
- Store 0xDEADBEEF to 0x10, slave always ready → AWVALID=WVALID=1 at cycle 1; BREADY at cycle 2; rsp_valid at cycle 3 with rsp_err=0. Then load from 0x10 → rsp_rdata=0xDEADBEEF at cycle 3.
- Write with AWREADY delayed 3 cycles and WREADY immediate → WVALID drops after 1 cycle; AWVALID held with AWADDR stable; rsp_valid exactly once.
- Load with RVALID delayed 5 cycles and RRESP=2'b10 → rsp_err=1, req_ready=0 throughout, single rsp_valid pulse.
- Back-to-back requests with req_valid held high → second accepted only the cycle after the first rsp_valid; no overlapping VALIDs.
- rstn pulsed low while in WR_B → all VALID/READY outputs 0 asynchronously; no rsp_valid; next request works normally.
- With CPU_AXI_ALIGN_CHECK_EN, load from 0x13 → no ARVALID ever; rsp_valid the cycle after acceptance with rsp_err=1 and rsp_rdata=0.
